// File: rtl/mmu_arbiter_pkg.sv
// Shared definitions for the MMU arbiter: FSM state encoding and parameter
// defaults used by mmu_arbiter and its priority picker.
package mmu_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_MAX_DM_RUN = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2
  } state_e;

endpackage

// File: rtl/mmu_arb_pick.sv
// Combinational grant selection between the fetch (if) and data (dm)
// requesters. Data wins a tie unless it has already taken MAX_DM_RUN grants
// in a row while a fetch was waiting, in which case the fetch goes first.
// Ports:
//   if_req_i, dm_req_i  pending requests
//   dm_run_cnt_i        consecutive dm grants taken while if_req was high
//   grant_if_o          fetch selected
//   grant_dm_o          data access selected
module mmu_arb_pick #(
  parameter int unsigned MAX_DM_RUN = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic             if_req_i,
  input  logic             dm_req_i,
  input  logic [CNT_W-1:0] dm_run_cnt_i,
  output logic             grant_if_o,
  output logic             grant_dm_o
);

  logic dm_starving_if;

  assign dm_starving_if = (dm_run_cnt_i == CNT_W'(MAX_DM_RUN));

  always_comb begin
    grant_if_o = 1'b0;
    grant_dm_o = 1'b0;
    if (dm_req_i && !(if_req_i && dm_starving_if)) begin
      grant_dm_o = 1'b1;
    end else if (if_req_i) begin
      grant_if_o = 1'b1;
    end
  end

endmodule

// File: rtl/mmu_arbiter.sv
// Arbitrates instruction-fetch and data-memory requests onto a single MMU
// port. One access is in flight at a time; an IDLE cycle separates accesses.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   if_req/if_addr              fetch request (word read)
//   if_ready/if_rdata/if_stall  fetch completion, data, pipeline hold
//   dm_req/dm_we/dm_byte/dm_addr/dm_wdata   data request and fields
//   dm_ready/dm_rdata/dm_stall  data completion, load data, pipeline hold
//   mmu_req/mmu_we/mmu_byte/mmu_addr/mmu_wdata  latched access to MMU
//   mmu_done/mmu_rdata          MMU completion pulse and read data
module mmu_arbiter
  import mmu_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned MAX_DM_RUN = DEF_MAX_DM_RUN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic              dm_byte,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              if_stall,
  output logic              dm_stall,
  output logic              mmu_req,
  output logic              mmu_we,
  output logic              mmu_byte,
  output logic [ADDR_W-1:0] mmu_addr,
  output logic [DATA_W-1:0] mmu_wdata,
  input  logic              mmu_done,
  input  logic [DATA_W-1:0] mmu_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_DM_RUN + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  dm_run_q, dm_run_d;
  logic              we_q, we_d;
  logic              byte_q, byte_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              grant_if, grant_dm;

  mmu_arb_pick #(
    .MAX_DM_RUN (MAX_DM_RUN),
    .CNT_W      (CNT_W)
  ) u_pick (
    .if_req_i     (if_req),
    .dm_req_i     (dm_req),
    .dm_run_cnt_i (dm_run_q),
    .grant_if_o   (grant_if),
    .grant_dm_o   (grant_dm)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dm_run_q <= '0;
      we_q     <= 1'b0;
      byte_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      dm_run_q <= dm_run_d;
      we_q     <= we_d;
      byte_q   <= byte_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dm_run_d = dm_run_q;
    we_d     = we_q;
    byte_d   = byte_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    if_ready = 1'b0;
    dm_ready = 1'b0;
    if_rdata = '0;
    dm_rdata = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_dm) begin
          state_d = ST_BUSY_DM;
          we_d    = dm_we;
          byte_d  = dm_byte;
          addr_d  = dm_addr;
          wdata_d = dm_wdata;
          // Run length only counts while a fetch is actually being held off.
          if (!if_req) begin
            dm_run_d = '0;
          end else if (dm_run_q != CNT_W'(MAX_DM_RUN)) begin
            dm_run_d = dm_run_q + CNT_W'(1);
          end
        end else if (grant_if) begin
          state_d  = ST_BUSY_IF;
          we_d     = 1'b0;
          byte_d   = 1'b0;
          addr_d   = if_addr;
          wdata_d  = '0;
          dm_run_d = '0;
        end
      end
      // Ready is suppressed while rst is high: the access is being abandoned.
      ST_BUSY_IF: begin
        if (mmu_done && !rst) begin
          if_ready = 1'b1;
          if_rdata = mmu_rdata;
          state_d  = ST_IDLE;
        end
      end
      ST_BUSY_DM: begin
        if (mmu_done && !rst) begin
          dm_ready = 1'b1;
          dm_rdata = mmu_rdata;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mmu_req   = (state_q != ST_IDLE);
  assign mmu_we    = we_q;
  assign mmu_byte  = byte_q;
  assign mmu_addr  = addr_q;
  assign mmu_wdata = wdata_q;
  assign if_stall  = if_req & ~if_ready;
  assign dm_stall  = dm_req & ~dm_ready;

endmodule

// File: tb/tb_mmu_arbiter.sv
module tb_mmu_arbiter;
  import mmu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we, dm_byte, mmu_done;
  logic [31:0] if_addr, dm_addr, dm_wdata, mmu_rdata;
  logic        if_ready, dm_ready, if_stall, dm_stall;
  logic        mmu_req, mmu_we, mmu_byte;
  logic [31:0] if_rdata, dm_rdata, mmu_addr, mmu_wdata;

  int unsigned total = 0;
  int unsigned bad   = 0;

  mmu_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .MAX_DM_RUN (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_byte   (dm_byte),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ready  (dm_ready),
    .dm_rdata  (dm_rdata),
    .if_stall  (if_stall),
    .dm_stall  (dm_stall),
    .mmu_req   (mmu_req),
    .mmu_we    (mmu_we),
    .mmu_byte  (mmu_byte),
    .mmu_addr  (mmu_addr),
    .mmu_wdata (mmu_wdata),
    .mmu_done  (mmu_done),
    .mmu_rdata (mmu_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ifr;
    logic [31:0] ifa;
    logic        dmr, we, by;
    logic [31:0] dma, wd;
    logic        done;
    logic [31:0] rd;
    logic        e_mreq, e_mwe, e_mbyte;
    logic [31:0] e_maddr, e_mwd;
    logic        e_ifrdy;
    logic [31:0] e_ifrd;
    logic        e_dmrdy;
    logic [31:0] e_dmrd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic r, logic ir, logic [31:0] ia, logic dr, logic w, logic b,
    logic [31:0] da, logic [31:0] wdat, logic dn, logic [31:0] rdat,
    logic emq, logic emw, logic emb, logic [31:0] ema, logic [31:0] emd,
    logic eir, logic [31:0] eird, logic edr, logic [31:0] edrd);
    vec_t v;
    v.rst = r; v.ifr = ir; v.ifa = ia; v.dmr = dr; v.we = w; v.by = b;
    v.dma = da; v.wd = wdat; v.done = dn; v.rd = rdat;
    v.e_mreq = emq; v.e_mwe = emw; v.e_mbyte = emb; v.e_maddr = ema;
    v.e_mwd = emd; v.e_ifrdy = eir; v.e_ifrd = eird; v.e_dmrdy = edr;
    v.e_dmrd = edrd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_byte = 1'b0; dm_addr = '0; dm_wdata = '0; mmu_done = 1'b0; mmu_rdata = '0;
  endtask

  initial begin
    bit exp_dm;
    // Cycle-by-cycle directed vectors; outputs checked mid-cycle.
    vecs.push_back(mk(1,0,32'h0,0,0,0,32'h0,32'h0,1,32'hDEAD, 0,0,0,32'h0,32'h0,0,32'h0,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,0,0,32'h0,32'h0,1,32'h1111, 0,0,0,32'h0,32'h0,0,32'h0,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,0,0,32'h0,32'h0,0,32'h0,    0,0,0,32'h0,32'h0,0,32'h0,0,32'h0));
    vecs.push_back(mk(0,1,32'h100,0,0,0,32'h0,32'h0,0,32'h0,  0,0,0,32'h0,32'h0,0,32'h0,0,32'h0));
    vecs.push_back(mk(0,1,32'h100,0,0,0,32'h0,32'h0,1,32'hAAAA5555, 1,0,0,32'h100,32'h0,1,32'hAAAA5555,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,0,0,32'h0,32'h0,0,32'h0,    0,0,0,32'h100,32'h0,0,32'h0,0,32'h0));
    vecs.push_back(mk(0,1,32'h80000000,0,0,0,32'h0,32'h0,0,32'h0, 0,0,0,32'h100,32'h0,0,32'h0,0,32'h0));
    vecs.push_back(mk(0,1,32'h80000000,0,0,0,32'h0,32'h0,0,32'h0, 1,0,0,32'h80000000,32'h0,0,32'h0,0,32'h0));
    vecs.push_back(mk(0,1,32'h80000000,0,0,0,32'h0,32'h0,0,32'h0, 1,0,0,32'h80000000,32'h0,0,32'h0,0,32'h0));
    vecs.push_back(mk(0,1,32'h80000000,0,0,0,32'h0,32'h0,1,32'hCAFEF00D, 1,0,0,32'h80000000,32'h0,1,32'hCAFEF00D,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,0,0,32'h0,32'h0,0,32'h0,    0,0,0,32'h80000000,32'h0,0,32'h0,0,32'h0));
    vecs.push_back(mk(0,1,32'h2000,1,1,0,32'h80400000,32'h12345678,0,32'h0, 0,0,0,32'h80000000,32'h0,0,32'h0,0,32'h0));
    vecs.push_back(mk(0,1,32'h2000,1,1,0,32'h80400000,32'h12345678,0,32'h0, 1,1,0,32'h80400000,32'h12345678,0,32'h0,0,32'h0));
    vecs.push_back(mk(0,1,32'h2000,1,1,0,32'h80400000,32'h12345678,1,32'h0, 1,1,0,32'h80400000,32'h12345678,0,32'h0,1,32'h0));
    vecs.push_back(mk(0,1,32'h2000,0,0,0,32'h0,32'h0,0,32'h0, 0,1,0,32'h80400000,32'h12345678,0,32'h0,0,32'h0));
    vecs.push_back(mk(0,1,32'h2000,0,0,0,32'h0,32'h0,1,32'h77, 1,0,0,32'h2000,32'h0,1,32'h77,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,0,0,32'h0,32'h0,0,32'h0,    0,0,0,32'h2000,32'h0,0,32'h0,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,0,1,32'h44,32'h0,0,32'h0,   0,0,0,32'h2000,32'h0,0,32'h0,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,0,0,32'h0,32'h0,0,32'h0,    1,0,1,32'h44,32'h0,0,32'h0,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,0,0,32'h0,32'h0,1,32'hBEEF, 1,0,1,32'h44,32'h0,0,32'h0,1,32'hBEEF));
    vecs.push_back(mk(0,0,32'h0,0,0,0,32'h0,32'h0,0,32'h0,    0,0,1,32'h44,32'h0,0,32'h0,0,32'h0));

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();

    foreach (vecs[i]) begin
      rst = vecs[i].rst; if_req = vecs[i].ifr; if_addr = vecs[i].ifa;
      dm_req = vecs[i].dmr; dm_we = vecs[i].we; dm_byte = vecs[i].by;
      dm_addr = vecs[i].dma; dm_wdata = vecs[i].wd;
      mmu_done = vecs[i].done; mmu_rdata = vecs[i].rd;
      #2;
      chk($sformatf("v%0d mmu_req", i),   64'(mmu_req),   64'(vecs[i].e_mreq));
      chk($sformatf("v%0d mmu_we", i),    64'(mmu_we),    64'(vecs[i].e_mwe));
      chk($sformatf("v%0d mmu_byte", i),  64'(mmu_byte),  64'(vecs[i].e_mbyte));
      chk($sformatf("v%0d mmu_addr", i),  64'(mmu_addr),  64'(vecs[i].e_maddr));
      chk($sformatf("v%0d mmu_wdata", i), 64'(mmu_wdata), 64'(vecs[i].e_mwd));
      chk($sformatf("v%0d if_ready", i),  64'(if_ready),  64'(vecs[i].e_ifrdy));
      chk($sformatf("v%0d if_rdata", i),  64'(if_rdata),  64'(vecs[i].e_ifrd));
      chk($sformatf("v%0d dm_ready", i),  64'(dm_ready),  64'(vecs[i].e_dmrdy));
      if (!(vecs[i].e_dmrdy && vecs[i].we))
        chk($sformatf("v%0d dm_rdata", i), 64'(dm_rdata), 64'(vecs[i].e_dmrd));
      chk($sformatf("v%0d if_stall", i),  64'(if_stall),  64'(vecs[i].ifr & ~vecs[i].e_ifrdy));
      chk($sformatf("v%0d dm_stall", i),  64'(dm_stall),  64'(vecs[i].dmr & ~vecs[i].e_dmrdy));
      tick();
    end

    // Starvation bound: both held high, expect dm,dm,dm,dm,if,dm,dm.
    idle_inputs();
    if_req = 1'b1; if_addr = 32'h1000;
    dm_req = 1'b1; dm_addr = 32'h3000;
    for (int g = 0; g < 7; g++) begin
      exp_dm = (g != 4);
      #2;
      chk($sformatf("run%0d idle mmu_req", g), 64'(mmu_req), 64'd0);
      tick();
      #2;
      chk($sformatf("run%0d busy mmu_req", g), 64'(mmu_req), 64'd1);
      chk($sformatf("run%0d grant addr", g), 64'(mmu_addr), exp_dm ? 64'h3000 : 64'h1000);
      mmu_done = 1'b1; mmu_rdata = 32'(g + 1);
      #1;
      chk($sformatf("run%0d dm_ready", g), 64'(dm_ready), 64'(exp_dm));
      chk($sformatf("run%0d if_ready", g), 64'(if_ready), 64'(!exp_dm));
      tick();
      mmu_done = 1'b0; mmu_rdata = '0;
    end

    // Reset during BUSY_DM, stray mmu_done afterwards.
    tick();
    #2;
    chk("rstmid busy", 64'(mmu_req), 64'd1);
    chk("rstmid dm owner", 64'(mmu_addr), 64'h3000);
    rst = 1'b1;
    #1;
    chk("rstmid no ready in rst", 64'(dm_ready), 64'd0);
    tick();
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    mmu_done = 1'b1; mmu_rdata = 32'h99;
    #2;
    chk("rstpost mmu_req", 64'(mmu_req), 64'd0);
    chk("rstpost dm_ready", 64'(dm_ready), 64'd0);
    chk("rstpost if_ready", 64'(if_ready), 64'd0);
    chk("rstpost dm_rdata", 64'(dm_rdata), 64'd0);
    chk("rstpost mmu_addr", 64'(mmu_addr), 64'd0);
    chk("rstpost mmu_wdata", 64'(mmu_wdata), 64'd0);
    chk("rstpost mmu_we", 64'(mmu_we), 64'd0);
    chk("rstpost state", 64'(dut.state_q), 64'(ST_IDLE));
    chk("rstpost run cnt", 64'(dut.dm_run_q), 64'd0);
    tick();
    mmu_done = 1'b0;
    #2;
    chk("rstpost2 mmu_req", 64'(mmu_req), 64'd0);
    chk("rstpost2 state", 64'(dut.state_q), 64'(ST_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
